// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared sector constants and pacer state for the CD sector FIFO
//
// Purpose: sector sizes, the receive-counter width, the pacer state encoding
// and a helper that maps the sector mode bit to its byte count.
// Ports: none (package).

package cd_pkg;

    localparam int SECT_DATA  = 2048;   // bytes per data sector (dm=0)
    localparam int SECT_AUDIO = 2352;   // bytes per CD-DA sector (dm=1)
    localparam int RX_CNT_W   = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } pacer_state_t;

    function automatic logic [RX_CNT_W-1:0] sector_len(input logic dm);
        return dm ? RX_CNT_W'(SECT_AUDIO) : RX_CNT_W'(SECT_DATA);
    endfunction

endpackage

// File: rtl/cd_fifo_ram.sv
// rtl/cd_fifo_ram.sv - simple dual-port 9-bit block RAM with registered read
//
// Purpose: storage for {dm, byte} entries of the sector FIFO.
// Ports:
//   clk_sys          clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr    read port; rd_data updates one cycle after rd_en and
//                    holds its value while rd_en is low
//   rd_data          registered read data

module cd_fifo_ram #(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_sys,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [8:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [8:0]    rd_data
);

    logic [8:0] mem [DEPTH];

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cd_sector_fifo.sv
// rtl/cd_sector_fifo.sv - sector byte FIFO with FWFT output and sector request pacer
//
// Purpose: buffers the sector byte stream pushed by data_io and issues a sector
// request only when a full CD-DA sector fits in the remaining space.
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   enable                    permit new sector requests
//   flush                     synchronous clear of FIFO and pacer
//   wr_data, wr_dm, wr_strobe byte push from data_io
//   out_data, out_dm, out_valid, out_ready   FWFT head and handshake
//   dat_req                   one-cycle sector request
//   halffull, level           registered fill indication
//   overflow                  sticky, a byte was dropped
//   sector_done, req_timeout  one-cycle pacer event pulses

module cd_sector_fifo
    import cd_pkg::*;
#(
    parameter int          DEPTH   = 8192,
    parameter logic [23:0] TIMEOUT = 24'd4000000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [7:0]             wr_data,
    input  logic                   wr_dm,
    input  logic                   wr_strobe,
    output logic [7:0]             out_data,
    output logic                   out_dm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   dat_req,
    output logic                   halffull,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   sector_done,
    output logic                   req_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] HALF_L  = LW'(DEPTH / 2);
    localparam logic [LW-1:0] AUDIO_L = LW'(SECT_AUDIO);

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       level_next;
    logic [LW-1:0]       unread;
    logic [LW-1:0]       free_space;
    logic [8:0]          ram_q;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic                push_drop;
    logic                rd_en;

    pacer_state_t        state;
    logic [RX_CNT_W-1:0] rx_cnt;
    logic [RX_CNT_W-1:0] rx_next;
    logic [RX_CNT_W-1:0] sect_len;
    logic [RX_CNT_W-1:0] len_now;
    logic [23:0]         idle_cnt;

    assign pop        = out_valid && out_ready;
    assign full       = (level_q == DEPTH_L);
    assign push_ok    = wr_strobe && (!full || pop);
    assign push_drop  = wr_strobe && full && !pop;
    assign level_next = level_q + LW'(push_ok) - LW'(pop);
    assign free_space = DEPTH_L - level_q;

    // The RAM read register is the head: entries still in RAM are the level
    // minus the head. A read is launched whenever the head is empty or leaving.
    assign unread = level_q - LW'(out_valid);
    assign rd_en  = !flush && (unread != '0) && (!out_valid || pop);

    cd_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_sys (clk_sys),
        .wr_en   (push_ok && !flush),
        .wr_addr (wr_ptr),
        .wr_data ({wr_dm, wr_data}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // The RAM register is not reset, so mask it while no head is held.
    assign out_data = out_valid ? ram_q[7:0] : 8'd0;
    assign out_dm   = out_valid && ram_q[8];
    assign level    = level_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            out_valid <= 1'b0;
            halffull  <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            out_valid <= 1'b0;
            halffull  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            level_q  <= level_next;
            halffull <= (level_next >= HALF_L);
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // The first byte of a sector decides its length; later bytes use the latch.
    assign rx_next = rx_cnt + 1'b1;
    assign len_now = (rx_cnt == '0) ? sector_len(wr_dm) : sect_len;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rx_cnt      <= '0;
            sect_len    <= '0;
            idle_cnt    <= '0;
            dat_req     <= 1'b0;
            sector_done <= 1'b0;
            req_timeout <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            rx_cnt      <= '0;
            idle_cnt    <= '0;
            dat_req     <= 1'b0;
            sector_done <= 1'b0;
            req_timeout <= 1'b0;
        end else begin
            dat_req     <= 1'b0;
            sector_done <= 1'b0;
            req_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // Request only when a worst-case (audio) sector fits.
                    if (enable && (free_space >= AUDIO_L)) begin
                        dat_req  <= 1'b1;
                        rx_cnt   <= '0;
                        idle_cnt <= '0;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    // Dropped bytes still count: the sender has moved on.
                    if (wr_strobe) begin
                        rx_cnt   <= rx_next;
                        idle_cnt <= '0;
                        if (rx_cnt == '0) begin
                            sect_len <= len_now;
                        end
                        if (rx_next == len_now) begin
                            sector_done <= 1'b1;
                            state       <= IDLE;
                        end
                    end else if (idle_cnt + 24'd1 == TIMEOUT) begin
                        req_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cd_sector_fifo.sv
// tb/tb_cd_sector_fifo.sv - randomized self-checking bench for cd_sector_fifo

module tb_cd_sector_fifo;
    import cd_pkg::*;

    localparam int DEPTH = 8192;
    localparam int TO    = 300;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_sys   = 1'b0;
    logic          reset_n   = 1'b0;
    logic          enable    = 1'b0;
    logic          flush     = 1'b0;
    logic [7:0]    wr_data   = 8'd0;
    logic          wr_dm     = 1'b0;
    logic          wr_strobe = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_dm;
    logic          out_valid;
    logic          dat_req;
    logic          halffull;
    logic [LW-1:0] level;
    logic          overflow;
    logic          sector_done;
    logic          req_timeout;

    always #5 clk_sys = ~clk_sys;

    cd_sector_fifo #(
        .DEPTH   (DEPTH),
        .TIMEOUT (24'(TO))
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .enable      (enable),
        .flush       (flush),
        .wr_data     (wr_data),
        .wr_dm       (wr_dm),
        .wr_strobe   (wr_strobe),
        .out_data    (out_data),
        .out_dm      (out_dm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dat_req     (dat_req),
        .halffull    (halffull),
        .level       (level),
        .overflow    (overflow),
        .sector_done (sector_done),
        .req_timeout (req_timeout)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference: a queue of stored entries tagged with the cycle they were
    // pushed; an entry may be at the head from two cycles after its push.
    typedef struct {
        logic [8:0] v;
        int         t;
    } ent_t;
    ent_t q[$];

    bit m_open  = 1'b0;   // a request is outstanding
    bit m_ovf   = 1'b0;
    bit prev_hf = 1'b0;
    int m_got   = 0;
    int m_need  = 0;
    int m_quiet = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        bit ev, pop, acc, e_req, e_done, e_to;
        ev = (q.size() > 0) && (q[0].t <= cyc - 2);
        expect_eq("out_valid", out_valid, ev);
        if (ev) begin
            expect_eq("out_data", out_data, q[0].v[7:0]);
            expect_eq("out_dm", out_dm, q[0].v[8]);
        end
        pop    = ev && out_ready;
        e_req  = 1'b0;
        e_done = 1'b0;
        e_to   = 1'b0;
        if (flush) begin
            q.delete();
            m_ovf  = 1'b0;
            m_open = 1'b0;
        end else begin
            if (!m_open) begin
                if (enable && (DEPTH - q.size()) >= SECT_AUDIO) begin
                    e_req   = 1'b1;
                    m_open  = 1'b1;
                    m_got   = 0;
                    m_quiet = 0;
                end
            end else if (wr_strobe) begin
                m_got++;
                m_quiet = 0;
                if (m_got == 1) m_need = wr_dm ? SECT_AUDIO : SECT_DATA;
                if (m_got == m_need) begin
                    e_done = 1'b1;
                    m_open = 1'b0;
                end
            end else begin
                m_quiet++;
                if (m_quiet == TO) begin
                    e_to   = 1'b1;
                    m_open = 1'b0;
                end
            end
            acc = wr_strobe && (q.size() < DEPTH || pop);
            if (wr_strobe && !acc) m_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{v: {wr_dm, wr_data}, t: cyc});
        end
        @(posedge clk_sys);
        #1;
        cyc++;
        expect_eq("level", level, q.size());
        expect_eq("halffull", halffull, q.size() >= DEPTH / 2);
        expect_eq("overflow", overflow, m_ovf);
        expect_eq("dat_req", dat_req, e_req);
        expect_eq("sector_done", sector_done, e_done);
        expect_eq("req_timeout", req_timeout, e_to);
        if (halffull && !prev_hf) expect_eq("hf_rise_level", level, DEPTH / 2);
        prev_hf = halffull;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic dm);
        wr_data   = d;
        wr_dm     = dm;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!dat_req && n < 2 * TO + 10);
        expect_eq("wait_req", dat_req, 1);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < DEPTH + 20) begin
            tick();
            n++;
        end
        expect_eq("drain_empty", level, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  nreq, npop, n, len, guard;
        logic dm;

        // Reset state
        repeat (5) @(posedge clk_sys);
        #1;
        expect_eq("rst_out_valid", out_valid, 0);
        expect_eq("rst_level", level, 0);
        expect_eq("rst_dat_req", dat_req, 0);
        expect_eq("rst_halffull", halffull, 0);
        expect_eq("rst_overflow", overflow, 0);
        expect_eq("rst_sector_done", sector_done, 0);
        expect_eq("rst_req_timeout", req_timeout, 0);
        expect_eq("rst_out_data", out_data, 0);
        enable  = 1'b1;
        reset_n = 1'b1;

        // Request after reset, then one data sector with random gaps/ready
        tick();
        expect_eq("req_after_reset", dat_req, 1);
        nreq = 0;
        for (int i = 0; i < SECT_DATA; i++) begin
            int gap = $urandom_range(0, 2);
            out_ready = 1'($urandom_range(0, 1));
            enable    = (i >= 500 && i < 1500) ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int g = 0; g < gap; g++) begin
                tick();
                nreq += int'(dat_req);
            end
            push_byte(8'($urandom), 1'b0);
            if (i < SECT_DATA - 1) nreq += int'(dat_req);
        end
        expect_eq("data_sector_done", sector_done, 1);
        expect_eq("no_req_mid_sector", nreq, 0);
        tick();
        expect_eq("req_after_done", dat_req, 1);

        // Audio sector held, then popped back to back
        drain();
        wait_req();
        out_ready = 1'b0;
        for (int i = 0; i < SECT_AUDIO; i++) push_byte(8'(i % 256), 1'b1);
        expect_eq("audio_sector_done", sector_done, 1);
        expect_eq("audio_level", level, SECT_AUDIO);
        expect_eq("audio_halffull", halffull, 0);
        out_ready = 1'b1;
        npop = 0;
        for (int i = 0; i < SECT_AUDIO; i++) begin
            if (out_valid) npop++;
            tick();
        end
        expect_eq("audio_pops_no_bubble", npop, SECT_AUDIO);
        out_ready = 1'b0;

        // Timeout after a partial sector
        wait_req();
        for (int i = 0; i < 100; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            push_byte(8'($urandom), 1'($urandom_range(0, 1)));
        end
        out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!req_timeout && n < TO + 20);
        expect_eq("timeout_cycles", n, TO);
        tick();
        expect_eq("rereq_after_timeout", dat_req, 1);

        // Fill to full, then overflow and pop+push at full
        drain();
        guard = 0;
        while ((DEPTH - q.size()) >= SECT_AUDIO && guard < 8) begin
            wait_req();
            dm  = 1'($urandom_range(0, 1));
            len = dm ? SECT_AUDIO : SECT_DATA;
            for (int i = 0; i < len; i++) push_byte(8'($urandom), dm);
            guard++;
        end
        nreq = 0;
        repeat (50) begin
            tick();
            nreq += int'(dat_req);
        end
        expect_eq("no_req_without_space", nreq, 0);
        n = 0;
        while (q.size() < DEPTH && n < DEPTH) begin
            push_byte(8'($urandom), 1'b0);
            n++;
        end
        expect_eq("full_level", level, DEPTH);
        repeat (5) push_byte(8'($urandom), 1'b0);
        expect_eq("overflow_set", overflow, 1);
        expect_eq("level_after_drop", level, DEPTH);
        out_ready = 1'b1;
        push_byte(8'hA5, 1'b1);
        out_ready = 1'b0;
        expect_eq("full_pop_push_level", level, DEPTH);
        expect_eq("full_pop_push_ovf", overflow, 1);

        // Flush mid-sector with a coincident push and pop
        drain();
        wait_req();
        for (int i = 0; i < 500; i++) push_byte(8'($urandom), 1'b0);
        expect_eq("pre_flush_level", level, 500);
        flush     = 1'b1;
        wr_strobe = 1'b1;
        wr_data   = 8'h5A;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        wr_strobe = 1'b0;
        out_ready = 1'b0;
        expect_eq("flush_level", level, 0);
        expect_eq("flush_out_valid", out_valid, 0);
        expect_eq("flush_overflow", overflow, 0);
        expect_eq("flush_dat_req", dat_req, 0);
        expect_eq("flush_sector_done", sector_done, 0);
        expect_eq("flush_req_timeout", req_timeout, 0);
        tick();
        expect_eq("req_after_flush", dat_req, 1);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cd_sector_fifo.md
Name: cd_sector_fifo

Overview:
- Byte FIFO and request pacer downstream of the PCE data_io SPI block.
- Accepts the sector byte stream (cd_data_out / cd_data_out_strobe / cd_dm) pushed by the IO controller.
- Buffers the bytes for the CD-ROM interface.
- Generates the cd_dat_req pulse and cd_fifo_halffull level that data_io reports back to the controller, so sectors are only requested when there is room for them.

Parameters:
- DEPTH, 8192: FIFO entries, each 9 bits {dm, byte}; power of two, must be at least 2*SECT_AUDIO.
- SECT_DATA, 2048: bytes per data sector (dm=0).
- SECT_AUDIO, 2352: bytes per CD-DA sector (dm=1).
- TIMEOUT, 24'd4000000: clk_sys cycles without a byte before an outstanding request is abandoned.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  permit new sector requests
- flush  in  1  synchronous clear of FIFO and pacer (driven from cd_reset_req)
- wr_data  in  8  byte from data_io (cd_data_out)
- wr_dm  in  1  sector mode from data_io (cd_dm)
- wr_strobe  in  1  one-cycle push (cd_data_out_strobe)
- out_data  out  8  head byte
- out_dm  out  1  mode of the head byte
- out_valid  out  1  head valid
- out_ready  in  1  consumer accepts the head
- dat_req  out  1  one-cycle sector request, to data_io cd_dat_req
- halffull  out  1  level >= DEPTH/2, to data_io cd_fifo_halffull
- level  out  $clog2(DEPTH)+1  entries held, including the output register
- overflow  out  1  sticky: a byte was dropped
- sector_done  out  1  one-cycle pulse when a full sector has been received
- req_timeout  out  1  one-cycle pulse when a request is abandoned

Behaviour:
- Reset: all outputs 0; level 0; state IDLE; FIFO empty.
- Storage: simple dual-port RAM with a 1-cycle read. The output stage is first-word-fall-through (FWFT), and a prefetch register keeps out_valid high across back-to-back pops.
- Push timing: a pushed byte reaches an empty head in 2 cycles, with out_valid high on the 2nd cycle after wr_strobe.
- Pop: occurs when out_valid && out_ready; level decrements on the same edge.
- Push acceptance: a push is accepted when level < DEPTH, or when level == DEPTH and a pop happens in the same cycle (level unchanged).
- Push at full with no pop: the byte is dropped and overflow is set; overflow clears only on flush or reset.
- Simultaneous push and pop at level 0: the byte is accepted; level goes to 1 and out_valid rises 2 cycles later.
- halffull and level are registered and updated on the cycle after the push or pop.
- Pacer FSM, state IDLE:
  - Condition: enable && !flush && (DEPTH - level) >= SECT_AUDIO.
  - Action: pulse dat_req for 1 cycle, clear rx_cnt and the idle timer, go to RECV.
- Pacer FSM, state RECV:
  - Each accepted or dropped push increments rx_cnt and clears the idle timer.
  - The first byte latches sect_len: SECT_AUDIO if wr_dm=1, else SECT_DATA.
  - Later bytes do not change sect_len.
  - When rx_cnt reaches sect_len: pulse sector_done, go to IDLE. A new dat_req may fire on the following cycle.
  - Idle timer reaching TIMEOUT: pulse req_timeout, go to IDLE.
- Pushes while IDLE (unsolicited) are stored normally but counted toward no sector.
- enable dropping mid-RECV does not abort the sector; it only blocks the next request.
- flush:
  - Effect: level=0, out_valid=0, overflow=0, pointers reset, FSM to IDLE. No dat_req, sector_done or req_timeout fires that cycle.
  - Priority: flush beats a simultaneous push (byte discarded) and a simultaneous pop.
- Reset asserted mid-sector: immediate return to the reset state. No pulse is emitted on deassertion.
- Widths: pointers are $clog2(DEPTH) bits with natural wrap; level is one bit wider; rx_cnt is 12 bits.

Decomposition:
- Shared package cd_pkg: SECT_DATA and SECT_AUDIO constants, and the pacer state enum (IDLE, RECV).
- One sub-module, cd_fifo_ram: an inferred simple dual-port 9-bit x DEPTH block RAM with registered read.
- The FWFT output logic, level counting and pacer live in the top module.

Test Plan:
- Request after reset: reset_n low for 5 cycles then high, enable=1.
  - dat_req pulses exactly once, 1 cycle after reset release.
  - No second dat_req until 2048 bytes with wr_dm=0 arrive; then sector_done pulses and the next dat_req follows 1 cycle later.
- Audio sector and data integrity: push 2352 bytes, wr_dm=1, values i mod 256, out_ready held 0.
  - sector_done on byte 2352; level=2352; halffull=0.
  - Then out_ready=1: 2352 consecutive pops of 0,1,...,255,0,... with out_dm=1 and no bubbles.
- Fill and overflow: DEPTH=8192, out_ready=0, enable=1.
  - Requests continue only while free space >= 2352.
  - halffull rises when level hits 4096.
  - Extra pushes forced at level 8192 drop with overflow=1; a pop plus push at level 8192 keeps level=8192 and overflow unchanged.
- Timeout: after dat_req, send 100 bytes then stop. req_timeout pulses TIMEOUT cycles after the last byte, and the FSM re-requests while space allows.
- Flush mid-sector: flush during RECV at level=500, coinciding with a push and a pop.
  - Next cycle: level=0, out_valid=0, overflow=0, no pulses.
  - One cycle after flush drops, a fresh dat_req fires.
